// File: rtl/pool_softmax_ctrl.sv
// Window max/argmax controller: streams win_len samples per window into an
// external running-max datapath and hands out one result per window.
module pool_softmax_ctrl #(
  parameter int PSUM_WID = 16,
  parameter int CNT_WID  = 8,
  parameter int IDX_WID  = 8,
  parameter int NWIN_WID = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_WID-1:0]  win_len,
  input  logic [NWIN_WID-1:0] num_win,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  input  logic [PSUM_WID-1:0] in_data,
  output logic                in_ready,
  output logic                dp_clear,
  output logic                dp_en,
  output logic [CNT_WID-1:0]  dp_cnt,
  output logic [PSUM_WID-1:0] dp_data_in,
  input  logic [PSUM_WID-1:0] dp_data_out,
  input  logic [IDX_WID-1:0]  dp_idx,
  output logic                res_valid,
  output logic [PSUM_WID-1:0] res_data,
  output logic [IDX_WID-1:0]  res_idx,
  input  logic                res_ready
);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT, OUT} state_t;

  state_t              state, state_nxt;
  logic [CNT_WID-1:0]  win_len_q;
  logic [NWIN_WID-1:0] num_win_q;
  logic [NWIN_WID-1:0] win_cnt;
  logic                start_ok;
  logic                last_sample;
  logic                last_win;
  logic                res_hs;

  assign start_ok    = (win_len != '0) && (num_win != '0);
  assign last_sample = (dp_cnt == win_len_q - CNT_WID'(1));
  assign last_win    = ((win_cnt + NWIN_WID'(1)) == num_win_q);
  assign res_hs      = res_valid & res_ready;

  assign dp_data_in  = in_data;
  assign dp_en       = in_valid & in_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    dp_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && start_ok) state_nxt = CLR;
      end
      CLR: begin
        dp_clear  = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid && last_sample) state_nxt = WAIT;
      end
      WAIT: state_nxt = OUT;
      OUT: begin
        if (res_hs) state_nxt = last_win ? IDLE : CLR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_len_q <= '0;
      num_win_q <= '0;
      win_cnt   <= '0;
      dp_cnt    <= '0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              win_len_q <= win_len;
              num_win_q <= num_win;
              win_cnt   <= '0;
              dp_cnt    <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        CLR: dp_cnt <= '0;
        STREAM: begin
          // The final index is held rather than wrapped so dp_cnt never aliases.
          if (dp_en && !last_sample) dp_cnt <= dp_cnt + CNT_WID'(1);
        end
        WAIT: begin
          res_data  <= dp_data_out;
          res_idx   <= dp_idx;
          res_valid <= 1'b1;
        end
        OUT: begin
          if (res_hs) begin
            res_valid <= 1'b0;
            win_cnt   <= win_cnt + NWIN_WID'(1);
            if (last_win) done   <= 1'b1;
            else          dp_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
